xregf_arb: RTL and testbench
============================

XREGF_ARB -- requirements
Module: xregf_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register file address width.
REQ-003 The block SHALL have parameter LOCK_MAX, default 8, meaning the maximum number of cycles a lock is held before forced release.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have ports host_req, host_we, host_lock, inputs, 1 bit each, for host access request, write enable and lock request.
REQ-007 The block SHALL have ports host_addr (input, ADDR_W) and host_wdata (input, DATA_W) for host address and write data.
REQ-008 The block SHALL have ports host_gnt, host_rvalid (outputs, 1 bit) and host_rdata (output, DATA_W) for host grant, read-data valid and read data.
REQ-009 The block SHALL have controller ports ctrl_req, ctrl_we, ctrl_lock, ctrl_addr, ctrl_wdata, ctrl_gnt, ctrl_rvalid and ctrl_rdata, with the same directions and widths as the host set.
REQ-010 The block SHALL have register-file ports regf_sel, regf_we (outputs, 1 bit), regf_addr (output, ADDR_W) and regf_wdata (output, DATA_W), plus regf_rdata (input, DATA_W).

Function
REQ-011 A transfer SHALL occur in any cycle where req and gnt are both 1 for one requester; the requester holds req, we, addr and wdata stable until it samples gnt=1.
REQ-012 At most one of host_gnt and ctrl_gnt SHALL be 1 in any cycle.
REQ-013 gnt SHALL be combinational from req, FSM state and the priority pointer, with zero-cycle grant latency.
REQ-014 regf_sel SHALL equal host_gnt|ctrl_gnt.
REQ-015 regf_we, regf_addr and regf_wdata SHALL be muxed from the granted requester, and SHALL be 0 when neither is granted.
REQ-016 FSM states SHALL be IDLE, LOCK_H and LOCK_C.
REQ-017 In IDLE with one request, that requester SHALL be granted.
REQ-018 In IDLE with both requesting, the requester not granted most recently SHALL win; pointer reset value = host wins first.
REQ-019 The priority pointer SHALL update on every completed transfer to mark the winner as most recent.
REQ-020 In IDLE, a granted transfer with its lock=1 SHALL move the FSM to LOCK_H or LOCK_C next cycle and clear the lock counter to 0.
REQ-021 In LOCK_x, only requester x SHALL be granted; the other requester's req is ignored.
REQ-022 In LOCK_x, a cycle with lock_x=0 SHALL return the FSM to IDLE next cycle; a transfer in that same cycle is still granted to x.
REQ-023 The lock counter SHALL increment each cycle in LOCK_x.
REQ-024 When the lock counter reaches LOCK_MAX-1, the FSM SHALL return to IDLE and the priority pointer SHALL favour the other requester, regardless of lock_x.
REQ-025 A forced lock release SHALL set an internal sticky flag so that lock_x is not honoured again until x deasserts lock for at least one cycle.
REQ-026 Read latency SHALL be 1 cycle: a granted read (we=0) in cycle N gives rvalid=1 for exactly one cycle in N+1 to that same requester, with rdata=regf_rdata.
REQ-027 rdata to the non-target requester SHALL be 0.
REQ-028 rvalid SHALL be 0 after a write and after an idle cycle.
REQ-029 Back-to-back reads, including by alternating requesters, SHALL be supported at one per cycle with no bubbles.

Reset
REQ-030 While rst=0, the FSM SHALL be IDLE, the priority pointer set to host-first, the lock counter and sticky flags 0, and both rvalid 0.
REQ-031 While rst=0, all gnt, regf_sel and regf_we SHALL be forced to 0.
REQ-032 rst asserted mid-lock or with a read outstanding SHALL drop the lock and discard the pending rvalid; the next access after release follows REQ-017/REQ-018.

Verification
REQ-033 After reset, both req=1 with reads at addr 2 and 5 -> host granted in cycle 0 and ctrl in cycle 1; host_rvalid=1 in cycle 1 and ctrl_rvalid=1 in cycle 2 with the matching regf_rdata.
REQ-034 Host write addr 3 data 0xDEADBEEF, then ctrl read addr 3 -> ctrl_rdata=0xDEADBEEF one cycle after ctrl_gnt.
REQ-035 ctrl_lock=1 held with ctrl_req=1 continuously while host_req=1 -> host_gnt=0 for exactly LOCK_MAX cycles of LOCK_C, then host granted.
REQ-036 ctrl lock deasserted after 3 locked transfers -> FSM returns to IDLE and host (pending) is granted the next cycle.
REQ-037 Continuous requests from both for 16 cycles -> grants alternate strictly with 8 grants each, one at a time (host_gnt & ctrl_gnt never both 1).
REQ-038 rst pulsed low during LOCK_H with a read outstanding -> no rvalid is seen, and after release ctrl alone requesting is granted immediately.

Source files
------------

// File: rtl/xregf_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : xregf_arb                                                  |
// | Description : Two-requester (host / controller) arbiter in front of a    |
// |               single-port register file. Round-robin tie-break, optional |
// |               bounded lock per requester, 1-cycle read-data return.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module xregf_arb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  // host requester
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // controller requester
  input  logic              ctrl_req,
  input  logic              ctrl_we,
  input  logic              ctrl_lock,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_gnt,
  output logic              ctrl_rvalid,
  output logic [DATA_W-1:0] ctrl_rdata,
  // register file side
  output logic              regf_sel,
  output logic              regf_we,
  output logic [ADDR_W-1:0] regf_addr,
  output logic [DATA_W-1:0] regf_wdata,
  input  logic [DATA_W-1:0] regf_rdata
);

  localparam int                 c_CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_H = 2'd1,
    LOCK_C = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;          // 1: controller wins the next tie
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               sticky_h_q, sticky_h_d; // lock ignored after a forced release
  logic               sticky_c_q, sticky_c_d;
  logic               rvalid_h_q, rvalid_c_q;

  logic               w_gnt_h;
  logic               w_gnt_c;

  // Grant decode: zero-latency, depends only on requests, state and pointer.
  always_comb begin
    w_gnt_h = 1'b0;
    w_gnt_c = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (host_req && ctrl_req) begin
            w_gnt_h = ~ptr_q;
            w_gnt_c = ptr_q;
          end else begin
            w_gnt_h = host_req;
            w_gnt_c = ctrl_req;
          end
        end
        LOCK_H:  w_gnt_h = host_req;
        LOCK_C:  w_gnt_c = ctrl_req;
        default: ;
      endcase
    end
  end

  // Next-state logic for FSM, priority pointer, lock counter and sticky flags.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    // A sticky flag survives only while the requester keeps lock asserted.
    sticky_h_d = sticky_h_q & host_lock;
    sticky_c_d = sticky_c_q & ctrl_lock;

    // Winner of a completed transfer becomes "most recent".
    if (w_gnt_h) begin
      ptr_d = 1'b1;
    end else if (w_gnt_c) begin
      ptr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (w_gnt_h && host_lock && !sticky_h_q) begin
          state_d = LOCK_H;
        end else if (w_gnt_c && ctrl_lock && !sticky_c_q) begin
          state_d = LOCK_C;
        end
      end
      LOCK_H: begin
        if (cnt_q == c_CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          ptr_d      = 1'b1;
          sticky_h_d = 1'b1;
        end else if (!host_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCK_C: begin
        if (cnt_q == c_CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          ptr_d      = 1'b0;
          sticky_c_d = 1'b1;
        end else if (!ctrl_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any lock and any pending read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      sticky_h_q <= 1'b0;
      sticky_c_q <= 1'b0;
      rvalid_h_q <= 1'b0;
      rvalid_c_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      sticky_h_q <= sticky_h_d;
      sticky_c_q <= sticky_c_d;
      rvalid_h_q <= w_gnt_h & ~host_we;
      rvalid_c_q <= w_gnt_c & ~ctrl_we;
    end
  end

  // Register-file request mux; all-zero when nobody is granted.
  always_comb begin
    regf_we    = 1'b0;
    regf_addr  = '0;
    regf_wdata = '0;
    if (w_gnt_h) begin
      regf_we    = host_we;
      regf_addr  = host_addr;
      regf_wdata = host_wdata;
    end else if (w_gnt_c) begin
      regf_we    = ctrl_we;
      regf_addr  = ctrl_addr;
      regf_wdata = ctrl_wdata;
    end
  end

  assign host_gnt    = w_gnt_h;
  assign ctrl_gnt    = w_gnt_c;
  assign regf_sel    = w_gnt_h | w_gnt_c;

  // Read data is steered only to the requester whose read is returning.
  assign host_rvalid = rvalid_h_q;
  assign ctrl_rvalid = rvalid_c_q;
  assign host_rdata  = rvalid_h_q ? regf_rdata : '0;
  assign ctrl_rdata  = rvalid_c_q ? regf_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_xregf_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_xregf_arb                                               |
// | Description : Directed self-checking bench for xregf_arb with a          |
// |               synchronous-read register file model and a read scoreboard.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_xregf_arb;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int LOCK_MAX = 8;

  logic              clk;
  logic              rst;
  logic              host_req, host_we, host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              ctrl_req, ctrl_we, ctrl_lock;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_wdata;
  logic              ctrl_gnt, ctrl_rvalid;
  logic [DATA_W-1:0] ctrl_rdata;
  logic              regf_sel, regf_we;
  logic [ADDR_W-1:0] regf_addr;
  logic [DATA_W-1:0] regf_wdata;
  logic [DATA_W-1:0] regf_rdata;

  xregf_arb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ctrl_req    (ctrl_req),
    .ctrl_we     (ctrl_we),
    .ctrl_lock   (ctrl_lock),
    .ctrl_addr   (ctrl_addr),
    .ctrl_wdata  (ctrl_wdata),
    .ctrl_gnt    (ctrl_gnt),
    .ctrl_rvalid (ctrl_rvalid),
    .ctrl_rdata  (ctrl_rdata),
    .regf_sel    (regf_sel),
    .regf_we     (regf_we),
    .regf_addr   (regf_addr),
    .regf_wdata  (regf_wdata),
    .regf_rdata  (regf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on content of every register-file word.
  function automatic logic [31:0] pat(input logic [3:0] a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_1011;
  endfunction

  // Register file: synchronous read, data available the cycle after selection.
  logic [31:0] mem [16];
  logic [15:0] wr_mask = '0;
  always @(posedge clk) begin
    if (regf_sel) begin
      if (regf_we) begin
        mem[regf_addr]     <= regf_wdata;
        wr_mask[regf_addr] <= 1'b1;
      end else begin
        regf_rdata <= wr_mask[regf_addr] ? mem[regf_addr] : pat(regf_addr);
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        hq[$];
  exp_t        cq[$];
  logic [31:0] ref_mem [16];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          hg_cnt = 0;
  int          cg_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs mid-cycle against the expected grant, run the
  // read scoreboard, record new expectations, then advance past the edge.
  task automatic tick(input logic eh, input logic ec, input string tag);
    logic        ew;
    logic [3:0]  ea;
    logic [31:0] ed;
    logic        exp_v;
    exp_t        e;
    @(negedge clk);
    ew = eh ? host_we    : (ec ? ctrl_we    : 1'b0);
    ea = eh ? host_addr  : (ec ? ctrl_addr  : 4'h0);
    ed = eh ? host_wdata : (ec ? ctrl_wdata : 32'h0);
    chk({tag, ".host_gnt"},   32'(host_gnt),   32'(eh));
    chk({tag, ".ctrl_gnt"},   32'(ctrl_gnt),   32'(ec));
    chk({tag, ".regf_sel"},   32'(regf_sel),   32'(eh | ec));
    chk({tag, ".regf_we"},    32'(regf_we),    32'(ew));
    chk({tag, ".regf_addr"},  32'(regf_addr),  32'(ea));
    chk({tag, ".regf_wdata"}, regf_wdata,      ed);
    if (host_gnt) hg_cnt++;
    if (ctrl_gnt) cg_cnt++;

    exp_v = (hq.size() > 0) && (hq[0].cyc == cyc);
    chk({tag, ".host_rvalid"}, 32'(host_rvalid), 32'(exp_v));
    if (exp_v) begin
      e = hq.pop_front();
      chk({tag, ".host_rdata"}, host_rdata, e.data);
    end else begin
      chk({tag, ".host_rdata0"}, host_rdata, 32'h0);
    end
    exp_v = (cq.size() > 0) && (cq[0].cyc == cyc);
    chk({tag, ".ctrl_rvalid"}, 32'(ctrl_rvalid), 32'(exp_v));
    if (exp_v) begin
      e = cq.pop_front();
      chk({tag, ".ctrl_rdata"}, ctrl_rdata, e.data);
    end else begin
      chk({tag, ".ctrl_rdata0"}, ctrl_rdata, 32'h0);
    end

    if (eh && !host_we) hq.push_back('{cyc + 1, ref_mem[host_addr]});
    if (eh && host_we)  ref_mem[host_addr] = host_wdata;
    if (ec && !ctrl_we) cq.push_back('{cyc + 1, ref_mem[ctrl_addr]});
    if (ec && ctrl_we)  ref_mem[ctrl_addr] = ctrl_wdata;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h0, c0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pat(4'(i));
    rst        = 1'b0;
    host_req   = 1'b1; host_we = 1'b0; host_lock = 1'b1;
    host_addr  = '0;   host_wdata = '0;
    ctrl_req   = 1'b1; ctrl_we = 1'b0; ctrl_lock = 1'b1;
    ctrl_addr  = '0;   ctrl_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    // Requests during reset must not be granted.
    tick(1'b0, 1'b0, "rst0");
    tick(1'b0, 1'b0, "rst1");
    host_lock = 1'b0;
    ctrl_lock = 1'b0;
    rst       = 1'b1;

    // Simultaneous reads: host first out of reset, then ctrl, rdata follows.
    host_req = 1'b1; host_addr = 4'd2;
    ctrl_req = 1'b1; ctrl_addr = 4'd5;
    tick(1'b1, 1'b0, "A0");
    host_req = 1'b0;
    tick(1'b0, 1'b1, "A1");
    ctrl_req = 1'b0;
    tick(1'b0, 1'b0, "A2");
    tick(1'b0, 1'b0, "A3");

    // Host write then ctrl read of the same word.
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd3; host_wdata = 32'hDEAD_BEEF;
    tick(1'b1, 1'b0, "B0");
    host_req = 1'b0; host_we = 1'b0;
    ctrl_req = 1'b1; ctrl_addr = 4'd3;
    tick(1'b0, 1'b1, "B1");
    ctrl_req = 1'b0;
    tick(1'b0, 1'b0, "B2");

    // Both requesting continuously: strict alternation, back-to-back reads.
    h0 = hg_cnt;
    c0 = cg_cnt;
    host_req = 1'b1;
    ctrl_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) host_addr = 4'(i);
      else            ctrl_addr = 4'(15 - i);
      tick(i % 2 == 0, i % 2 == 1, "C");
    end
    host_req = 1'b0;
    ctrl_req = 1'b0;
    chk("C.host_grants", 32'(hg_cnt - h0), 32'd8);
    chk("C.ctrl_grants", 32'(cg_cnt - c0), 32'd8);
    tick(1'b0, 1'b0, "C.end");

    // Ctrl holds lock: host starved for exactly LOCK_MAX cycles, then wins;
    // ctrl lock is not re-honoured while it stays asserted.
    ctrl_req = 1'b1; ctrl_lock = 1'b1; ctrl_addr = 4'd7;
    tick(1'b0, 1'b1, "D.enter");
    host_req = 1'b1; host_addr = 4'd1;
    for (int i = 0; i < LOCK_MAX; i++) tick(1'b0, 1'b1, "D.lockc");
    tick(1'b1, 1'b0, "D.release");
    host_req = 1'b0;
    tick(1'b0, 1'b1, "D.sticky");
    host_req = 1'b1;
    tick(1'b1, 1'b0, "D.after");
    host_req = 1'b0; ctrl_req = 1'b0; ctrl_lock = 1'b0;
    tick(1'b0, 1'b0, "D.end");

    // Voluntary unlock after three locked transfers; pending host follows.
    ctrl_req = 1'b1; ctrl_lock = 1'b1; ctrl_addr = 4'd4;
    tick(1'b0, 1'b1, "E.enter");
    host_req = 1'b1; host_addr = 4'd6;
    tick(1'b0, 1'b1, "E.lk1");
    tick(1'b0, 1'b1, "E.lk2");
    ctrl_lock = 1'b0;
    tick(1'b0, 1'b1, "E.unlock");
    ctrl_req = 1'b0;
    tick(1'b1, 1'b0, "E.host");
    host_req = 1'b0;
    tick(1'b0, 1'b0, "E.end");

    // Reset during host lock with a read in flight.
    host_req = 1'b1; host_lock = 1'b1; host_addr = 4'd9;
    tick(1'b1, 1'b0, "F.enter");
    host_addr = 4'd10;
    tick(1'b1, 1'b0, "F.lockh");
    rst = 1'b0;
    hq.delete();
    cq.delete();
    ctrl_req = 1'b1;
    tick(1'b0, 1'b0, "F.rst");
    rst = 1'b1;
    host_req = 1'b0; host_lock = 1'b0;
    ctrl_addr = 4'd1;
    tick(1'b0, 1'b1, "F.ctrl");
    ctrl_req = 1'b0;
    tick(1'b0, 1'b0, "F.end");

    chk("sb.host_left", 32'(hq.size()), 32'd0);
    chk("sb.ctrl_left", 32'(cq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
